// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: NUM_DIGITS BCD digits, active-low seg/an,
// dead cycle per slot, leading-zero suppression, blanking, load strobe/ack.
// Ports: clk, rst_n, load, bcd_in, lzs, blank -> load_ack, seg[6:0], an.
// Codes 10..15 show hex letters when SEG7_HEX_DECODE_EN is defined,
// and a dash otherwise.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lzs,
  input  logic                    blank,
  output logic                    load_ack,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CW   = $clog2(PRESCALE);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt;
  logic [IDXW-1:0]         idx;
  logic                    started;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic                    tick;
  logic [NUM_DIGITS:0]     lz;
  logic [3:0]              cur;
  logic                    supp;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0001000;
      4'd1:    s = 7'b1101101;
      4'd2:    s = 7'b0100010;
      4'd3:    s = 7'b0100100;
      4'd4:    s = 7'b1000101;
      4'd5:    s = 7'b0010100;
      4'd6:    s = 7'b0010000;
      4'd7:    s = 7'b0101101;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
`ifdef SEG7_HEX_DECODE_EN
      4'd10:   s = 7'b0000001;
      4'd11:   s = 7'b1010000;
      4'd12:   s = 7'b0011010;
      4'd13:   s = 7'b1100000;
      4'd14:   s = 7'b0010010;
      default: s = 7'b0010011;
`else
      default: s = 7'b1110111;
`endif
    endcase
    return s;
  endfunction

  assign tick = (cnt == CW'(PRESCALE - 1));

  // lz[k]: digit k and every digit above it are code 0
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--)
      lz[k] = lz[k+1] && (shadow[4*k +: 4] == 4'd0);
  end

  always_comb begin
    cur    = '0;
    supp   = 1'b0;
    an_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDXW'(k)) begin
        cur       = shadow[4*k +: 4];
        supp      = lzs && lz[k] && (k != 0);
        an_nxt[k] = 1'b0;
      end
    end
    seg_nxt = supp ? 7'h7f : dec(cur);
    // dead cycle after each tick, dark before the first tick and when blanked
    if (blank || tick || !started) begin
      seg_nxt = 7'h7f;
      an_nxt  = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      started  <= 1'b0;
      shadow   <= '0;
      seg      <= 7'h7f;
      an       <= '1;
      load_ack <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      load_ack <= load;
      seg      <= seg_nxt;
      an       <= an_nxt;
      if (load)
        shadow <= bcd_in;
      if (tick) begin
        started <= 1'b1;
        if (idx == IDXW'(NUM_DIGITS - 1))
          idx <= '0;
        else
          idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, PRESCALE=4.
// Ticks fall on edges 4, 8, 12, ... counted from the reset release.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic        lzs;
  logic        blank;
  logic        load_ack;
  logic [6:0]  seg;
  logic [3:0]  an;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  localparam logic [6:0] DARK = 7'h7f;
`ifdef SEG7_HEX_DECODE_EN
  localparam logic [6:0] SEG_C = 7'b0011010;
`else
  localparam logic [6:0] SEG_C = 7'b1110111;
`endif

  seg7_scan_driver #(
    .NUM_DIGITS(4),
    .PRESCALE(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .bcd_in(bcd_in),
    .lzs(lzs),
    .blank(blank),
    .load_ack(load_ack),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    bcd_in = '0;
    lzs    = 1'b0;
    blank  = 1'b0;
    step(2);
    chk("rst_seg", {1'b0, seg}, {1'b0, DARK});
    chk("rst_an", {4'h0, an}, 8'h0f);
    chk("rst_ack", {7'h0, load_ack}, 8'h00);

    // E1: capture 1234
    rst_n  = 1'b1;
    load   = 1'b1;
    bcd_in = 16'h1234;
    step(1);
    chk("ack1", {7'h0, load_ack}, 8'h01);
    chk("pre_an1", {4'h0, an}, 8'h0f);
    load = 1'b0;
    step(1);
    chk("ack1_off", {7'h0, load_ack}, 8'h00);
    step(1);
    chk("pre_an3", {4'h0, an}, 8'h0f);
    step(1);
    chk("dead4", {4'h0, an}, 8'h0f);
    step(1);
    chk("an_d1", {4'h0, an}, 8'h0d);
    chk("seg_d1", {1'b0, seg}, {1'b0, 7'b0100100});
    step(3);
    chk("dead8", {4'h0, an}, 8'h0f);
    step(1);
    chk("an_d2", {4'h0, an}, 8'h0b);
    chk("seg_d2", {1'b0, seg}, {1'b0, 7'b0100010});
    step(4);
    chk("an_d3", {4'h0, an}, 8'h07);
    chk("seg_d3", {1'b0, seg}, {1'b0, 7'b1101101});
    step(4);
    chk("an_d0", {4'h0, an}, 8'h0e);
    chk("seg_d0", {1'b0, seg}, {1'b0, 7'b1000101});

    // E18: capture 0070 with suppression, shown from E19 on digit 0
    load   = 1'b1;
    bcd_in = 16'h0070;
    lzs    = 1'b1;
    step(1);
    chk("ack2", {7'h0, load_ack}, 8'h01);
    load = 1'b0;
    step(1);
    chk("lz_an0", {4'h0, an}, 8'h0e);
    chk("lz_seg0", {1'b0, seg}, {1'b0, 7'b0001000});
    step(2);
    chk("lz_an1", {4'h0, an}, 8'h0d);
    chk("lz_seg1", {1'b0, seg}, {1'b0, 7'b0101101});
    step(4);
    chk("lz_an2", {4'h0, an}, 8'h0b);
    chk("lz_seg2", {1'b0, seg}, {1'b0, DARK});
    step(4);
    chk("lz_an3", {4'h0, an}, 8'h07);
    chk("lz_seg3", {1'b0, seg}, {1'b0, DARK});

    // E30: capture 000C, shown at E33 on digit 0
    load   = 1'b1;
    bcd_in = 16'h000c;
    lzs    = 1'b0;
    step(1);
    chk("ack3", {7'h0, load_ack}, 8'h01);
    load = 1'b0;
    step(3);
    chk("hex_an", {4'h0, an}, 8'h0e);
    chk("hex_seg", {1'b0, seg}, {1'b0, SEG_C});

    // blank over E35..E44; ticks at 36, 40, 44 move index 0 -> 3
    step(1);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("blank_seg", {1'b0, seg}, {1'b0, DARK});
      chk("blank_an", {4'h0, an}, 8'h0f);
    end
    blank = 1'b0;
    step(1);
    chk("unblank_an", {4'h0, an}, 8'h07);
    chk("unblank_seg", {1'b0, seg}, {1'b0, 7'b0001000});

    // async reset pulse while a load is pending
    load   = 1'b1;
    bcd_in = 16'h9999;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", {1'b0, seg}, {1'b0, DARK});
    chk("arst_an", {4'h0, an}, 8'h0f);
    chk("arst_ack", {7'h0, load_ack}, 8'h00);
    step(1);
    rst_n = 1'b1;
    load  = 1'b0;
    step(1);
    chk("arst_noack", {7'h0, load_ack}, 8'h00);
    step(2);
    chk("arst_pre", {4'h0, an}, 8'h0f);
    step(2);
    chk("arst_an1", {4'h0, an}, 8'h0d);
    chk("arst_shadow", {1'b0, seg}, {1'b0, 7'b0001000});

    // back-to-back loads, both acknowledged, last one wins
    load   = 1'b1;
    bcd_in = 16'h0005;
    step(1);
    chk("b2b_ack1", {7'h0, load_ack}, 8'h01);
    bcd_in = 16'h0008;
    step(1);
    chk("b2b_ack2", {7'h0, load_ack}, 8'h01);
    load = 1'b0;
    step(1);
    chk("b2b_ack_off", {7'h0, load_ack}, 8'h00);
    step(9);
    chk("b2b_an", {4'h0, an}, 8'h0e);
    chk("b2b_seg", {1'b0, seg}, {1'b0, 7'b0000000});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
